tick_period_meter: RTL and testbench
====================================

# tick_period_meter

Receive-side checker for the low-duty tick trains produced by the clock dividers. It detects rising edges on a one-cycle-high tick input and measures the number of `clk_in` cycles between consecutive edges. It compares each measurement against an expected period and flags a lost tick stream after a programmable timeout. It sits downstream of each divider and feeds status LEDs and debug logic.

## Interface
- No parameters; all widths fixed at 32 bits, matching the divider `period` input.
- `clk_in`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset; synchronous to `clk_in`, active-high.
- `tick_in`  in  1  tick stream; one cycle high per period; may idle high.
- `expected`  in  32  expected period in cycles; 0 disables the mismatch check.
- `timeout`  in  32  cycles without an edge before declaring loss; 0 disables timeout.
- `period_out`  out  32  last measured period; holds between measurements.
- `period_valid`  out  1  one-cycle strobe when `period_out` updates.
- `mismatch`  out  1  valid with `period_valid`; 1 if `period_out != expected` and `expected != 0`; holds until the next measurement.
- `lost`  out  1  high while in LOST.
- `locked`  out  1  high after a measurement that did not mismatch; cleared by mismatch, loss or reset.

## Operation
- Edge detect: `tick_prev` register; `edge = tick_in & ~tick_prev`. `tick_prev` resets to 1, so a tick held high through reset is not an edge (the divider resets with its output high).
- Cycle counter `cnt`, 32 bits, saturates at 0xFFFF_FFFF and never wraps.
- FSM states: IDLE, COUNT, LOST.
  - IDLE: wait for `edge`; on edge go to COUNT with `cnt <= 1`, no measurement.
  - COUNT, edge: `period_out <= cnt`, `period_valid <= 1`, `mismatch` and `locked` updated, `cnt <= 1`, stay in COUNT.
  - COUNT, no edge, `timeout != 0` and `cnt == timeout`: go to LOST; `locked <= 0`.
  - COUNT, otherwise: `cnt <= cnt + 1` (saturating).
  - LOST, edge: go to COUNT, `cnt <= 1`, `lost` clears, no measurement (first edge re-arms only).
- Simultaneous edge and `cnt == timeout`: the edge wins; the measurement is reported and no loss is flagged.
- `expected` and `timeout` are sampled every cycle. Changing them mid-count affects only the next comparison.

## Timing
- Reset values: state IDLE, `cnt` 0, `tick_prev` 1, `period_out` 0, `period_valid` 0, `mismatch` 0, `lost` 0, `locked` 0.
- Reset mid-operation: all of the above apply on the next edge of `clk_in`. The first edge after reset only arms the counter.
- With edges at cycles t0 and t1, `cnt` equals t1−t0 during cycle t1.
  - `period_out`, `period_valid`, `mismatch` and `locked` are registered and visible at cycle t1+1.
- A divider programmed with period P gives `period_out = P` for P ≥ 2. P = 1 holds the tick high, so no edges occur.
- Timeout: with the last edge at t0 and no further edge, `lost` rises at cycle t0+timeout+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `TICK_SYNC_EN` defined: `tick_in` passes through a two-flop synchronizer (both flops reset to 1) before edge detection.
  - The input may then be asynchronous to `clk_in`.
  - All output timings gain 2 cycles of latency; measured periods are unchanged.
- `TICK_SYNC_EN` undefined: `tick_in` feeds edge detection directly and must be synchronous to `clk_in`.

## Test plan
- Divider with P=5 drives `tick_in`, `expected=5`, `timeout=0` → the first `period_valid` comes one cycle after the second edge with `period_out=5`, `mismatch=0`, `locked=1`; it repeats every 5 cycles.
- Same stimulus with `expected=6` → `period_out=5`, `mismatch=1`, `locked=0` on every strobe.
- P=5, `timeout=20`, ticks stopped after edge t0 → `lost=1` at t0+21, `locked=0`. On resumed ticks, the first edge clears `lost` with no strobe; the second edge strobes `period_out=5`.
- `tick_in` held at 1 through reset and 50 cycles after → no `period_valid`, state stays IDLE, all outputs 0.
- `rst` pulsed for 1 cycle mid-count (P=8) → all outputs 0 the next cycle. The first post-reset edge gives no strobe; the second gives `period_out=8`.
- `timeout=7`, edges spaced exactly 7 cycles → strobe with `period_out=7`, `lost` never asserts.

Source files
------------

// File: rtl/tick_period_meter.sv
// rtl/tick_period_meter.sv - tick edge period meter with mismatch and loss detection (optional TICK_SYNC_EN input synchronizer)
module tick_period_meter (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tick_in,
  input  logic [31:0] expected,
  input  logic [31:0] timeout,
  output logic [31:0] period_out,
  output logic        period_valid,
  output logic        mismatch,
  output logic        lost,
  output logic        locked
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LOST  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        tick_prev_q, tick_prev_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        mismatch_q, mismatch_d;
  logic        lost_q, lost_d;
  logic        locked_q, locked_d;

  logic        tick_s;
  logic        tick_edge;
  logic        timed_out;
  logic        meas_bad;
  logic [31:0] cnt_inc;

`ifdef TICK_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Shift the raw tick through two flops; reset high so a high-idling divider is not an edge
  always_comb begin
    sync_d = {sync_q[0], tick_in};
  end

  // Synchronizer flops
  always_ff @(posedge clk_in) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  assign tick_s = sync_q[1];
`else
  assign tick_s = tick_in;
`endif

  assign tick_edge = tick_s & ~tick_prev_q;
  assign timed_out = (timeout != 32'd0) && (cnt_q == timeout);
  assign meas_bad  = (expected != 32'd0) && (cnt_q != expected);
  assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  // State register and all datapath flops
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_prev_q <= 1'b1;
      cnt_q       <= 32'd0;
      period_q    <= 32'd0;
      valid_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      lost_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_prev_q <= tick_prev_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      mismatch_q  <= mismatch_d;
      lost_q      <= lost_d;
      locked_q    <= locked_d;
    end
  end

  // Next-state: an edge always beats a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick_edge) state_d = S_COUNT;
      S_COUNT: if (!tick_edge && timed_out) state_d = S_LOST;
      S_LOST:  if (tick_edge) state_d = S_COUNT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: counter, measurement capture and status flags
  always_comb begin
    tick_prev_d = tick_s;
    cnt_d       = cnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    mismatch_d  = mismatch_q;
    locked_d    = locked_q;
    lost_d      = (state_d == S_LOST);
    case (state_q)
      S_IDLE: begin
        if (tick_edge) cnt_d = 32'd1;
      end
      S_COUNT: begin
        if (tick_edge) begin
          period_d   = cnt_q;
          valid_d    = 1'b1;
          mismatch_d = meas_bad;
          locked_d   = ~meas_bad;
          cnt_d      = 32'd1;
        end else if (timed_out) begin
          locked_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LOST: begin
        // First edge after loss only re-arms the counter
        if (tick_edge) cnt_d = 32'd1;
      end
      default: cnt_d = 32'd0;
    endcase
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign mismatch     = mismatch_q;
  assign lost         = lost_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// tb/tb_tick_period_meter.sv - scoreboard bench for tick_period_meter
module tb_tick_period_meter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        tick_in;
  logic [31:0] expected;
  logic [31:0] timeout;
  logic [31:0] period_out;
  logic        period_valid;
  logic        mismatch;
  logic        lost;
  logic        locked;

`ifdef TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] p;
    logic        m;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_edge;
  bit   lost_seen;

  tick_period_meter dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .tick_in     (tick_in),
    .expected    (expected),
    .timeout     (timeout),
    .period_out  (period_out),
    .period_valid(period_valid),
    .mismatch    (mismatch),
    .lost        (lost),
    .locked      (locked)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk_in) begin
    if (lost) lost_seen = 1'b1;
    if (period_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: period_out=%0d with empty scoreboard", period_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_period", period_out, e.p);
        check("strobe_mismatch", {31'd0, mismatch}, {31'd0, e.m});
        check("strobe_locked", {31'd0, locked}, {31'd0, e.l});
      end
    end
  end

  task automatic push(input int p);
    exp_t e;
    e.p = p;
    e.m = (expected != 32'd0) && (p != expected);
    e.l = ~e.m;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in); #1;
      tick_in = 1'b0;
    end
  endtask

  // n ticks spaced p cycles; when arm is set the first tick produces no measurement
  task automatic train(input int p, input int n, input bit arm);
    for (int e = 0; e < n; e++) begin
      @(posedge clk_in); #1;
      tick_in   = 1'b1;
      last_edge = cyc;
      if (!arm || e > 0) push(p);
      for (int k = 1; k < p; k++) begin
        @(posedge clk_in); #1;
        tick_in = 1'b0;
      end
    end
  endtask

  task automatic reset_dut();
    @(posedge clk_in); #1;
    rst     = 1'b1;
    tick_in = 1'b0;
    @(posedge clk_in); #1;
    rst = 1'b0;
    idle(4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period_out"}, period_out, 32'd0);
    check({tag, "_valid"}, {31'd0, period_valid}, 32'd0);
    check({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
    check({tag, "_lost"}, {31'd0, lost}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    tick_in  = 1'b1;
    expected = 32'd0;
    timeout  = 32'd0;
    repeat (3) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Tick held high from reset: never an edge
    for (int k = 0; k < 50; k++) begin
      @(posedge clk_in); #1;
      tick_in = 1'b1;
    end
    check_all_zero("held_high");

    // P=5 matching expected, with explicit strobe latency check
    reset_dut();
    expected = 32'd5;
    timeout  = 32'd0;
    train(5, 1, 1'b1);
    @(posedge clk_in); #1;
    tick_in = 1'b1;
    push(5);
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk_in); #1;
      tick_in = 1'b0;
    end
    check("latency_valid", {31'd0, period_valid}, 32'd1);
    check("latency_period", period_out, 32'd5);
    idle(4 - LAT);
    train(5, 3, 1'b0);
    idle(LAT + 2);
    check("p5_locked_hold", {31'd0, locked}, 32'd1);

    // P=5 against expected=6: mismatch every strobe
    reset_dut();
    expected = 32'd6;
    train(5, 4, 1'b1);
    idle(LAT + 2);
    check("p6_mismatch_hold", {31'd0, mismatch}, 32'd1);

    // Minimum period P=2
    reset_dut();
    expected = 32'd2;
    train(2, 4, 1'b1);
    idle(LAT + 2);

    // Loss after timeout=20, then recovery
    reset_dut();
    expected = 32'd5;
    timeout  = 32'd20;
    train(5, 3, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_in); #1;
      tick_in = 1'b0;
      if (lost) break;
    end
    check("lost_rise_cycle", cyc - last_edge, 20 + LAT);
    check("lost_locked", {31'd0, locked}, 32'd0);
    idle(3);
    train(5, 3, 1'b1);
    check("lost_cleared", {31'd0, lost}, 32'd0);
    timeout = 32'd0;
    idle(LAT + 2);

    // Reset pulse mid-count with P=8
    reset_dut();
    expected = 32'd8;
    train(8, 2, 1'b1);
    idle(3);
    check("pre_rst_locked", {31'd0, locked}, 32'd1);
    @(posedge clk_in); #1;
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    check_all_zero("mid_rst");
    idle(3);
    train(8, 2, 1'b1);
    idle(LAT + 2);

    // Edges exactly at timeout: edge wins, no loss
    reset_dut();
    expected  = 32'd7;
    timeout   = 32'd7;
    lost_seen = 1'b0;
    train(7, 4, 1'b1);
    check("no_lost_at_boundary", {31'd0, lost_seen}, 32'd0);
    timeout = 32'd0;
    idle(LAT + 4);

    check("scoreboard_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
